// File: rtl/change_dispenser.sv
// Greedy coin-change payout controller.
// A refund strobe in IDLE loads the balance; the FSM then alternates
// SELECT (pick the largest coin that still fits) and REQ (hold the coin
// request until the hopper takes it) until the remainder drops below the
// smallest coin. DONE pulses once, flagging any unpayable residue.
//
// Hopper handshake: in REQ, coin_req is 1 and coin_sel is stable; a coin
// transfers on every rising edge where coin_req=1 and coin_rdy=1. coin_req
// then drops for one SELECT cycle before the next coin. There is no timeout.
module change_dispenser #(
  parameter int unsigned D0 = 100,
  parameter int unsigned D1 = 50,
  parameter int unsigned D2 = 20,
  parameter int unsigned D3 = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refund,
  input  logic [9:0] balance,
  input  logic       coin_rdy,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic [9:0] remain,
  output logic [4:0] coin_cnt,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_SELECT = 3'b001,
    S_REQ    = 3'b010,
    S_DONE   = 3'b011
  } state_t;

  localparam logic [9:0] V0 = 10'(D0);
  localparam logic [9:0] V1 = 10'(D1);
  localparam logic [9:0] V2 = 10'(D2);
  localparam logic [9:0] V3 = 10'(D3);

  state_t      state_q, state_d;
  logic [1:0]  coin_sel_q, coin_sel_d;
  logic [9:0]  remain_q, remain_d;
  logic [4:0]  coin_cnt_q, coin_cnt_d;
  logic        error_q, error_d;
  logic [9:0]  coin_val;

  // Face value of the coin currently being requested.
  always_comb begin
    coin_val = V3;
    case (coin_sel_q)
      2'b00:   coin_val = V0;
      2'b01:   coin_val = V1;
      2'b10:   coin_val = V2;
      default: coin_val = V3;
    endcase
  end

  // Next-state and datapath updates; a coin is only chosen when it fits,
  // so the subtraction in REQ can never wrap.
  always_comb begin
    state_d    = state_q;
    coin_sel_d = coin_sel_q;
    remain_d   = remain_q;
    coin_cnt_d = coin_cnt_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (refund) begin
          remain_d   = balance;
          coin_cnt_d = 5'd0;
          error_d    = 1'b0;
          state_d    = S_SELECT;
        end
      end
      S_SELECT: begin
        state_d = S_REQ;
        if (remain_q >= V0)      coin_sel_d = 2'b00;
        else if (remain_q >= V1) coin_sel_d = 2'b01;
        else if (remain_q >= V2) coin_sel_d = 2'b10;
        else if (remain_q >= V3) coin_sel_d = 2'b11;
        else begin
          state_d = S_DONE;
          error_d = (remain_q != 10'd0);
        end
      end
      S_REQ: begin
        if (coin_rdy) begin
          remain_d   = remain_q - coin_val;
          coin_cnt_d = (coin_cnt_q == 5'd31) ? coin_cnt_q : coin_cnt_q + 5'd1;
          state_d    = S_SELECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any payout in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      coin_sel_q <= 2'b00;
      remain_q   <= 10'd0;
      coin_cnt_q <= 5'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      coin_sel_q <= coin_sel_d;
      remain_q   <= remain_d;
      coin_cnt_q <= coin_cnt_d;
      error_q    <= error_d;
    end
  end

  // Outputs are registers or pure decodes of the state register.
  always_comb begin
    coin_req = (state_q == S_REQ);
    done     = (state_q == S_DONE);
    busy     = (state_q == S_SELECT) || (state_q == S_REQ) || (state_q == S_DONE);
    state    = state_q;
    coin_sel = coin_sel_q;
    remain   = remain_q;
    coin_cnt = coin_cnt_q;
    error    = error_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with hand-computed expectations.
module tb_change_dispenser;

  logic       clk;
  logic       rst;
  logic       refund;
  logic [9:0] balance;
  logic       coin_rdy;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic [9:0] remain;
  logic [4:0] coin_cnt;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] state;

  int total;
  int bad;

  logic [1:0] exp_coin_q[$];
  logic [9:0] exp_rem_q[$];

  change_dispenser dut (
    .clk      (clk),
    .rst      (rst),
    .refund   (refund),
    .balance  (balance),
    .coin_rdy (coin_rdy),
    .coin_req (coin_req),
    .coin_sel (coin_sel),
    .remain   (remain),
    .coin_cnt (coin_cnt),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .state    (state)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_reset_values(input string tag);
    total++;
    if (state !== 3'b000 || coin_req !== 1'b0 || coin_sel !== 2'b00 ||
        remain !== 10'd0 || coin_cnt !== 5'd0 || busy !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL %s: state=%0d req=%b sel=%b rem=%0d cnt=%0d busy=%b done=%b err=%b, want all zero",
               tag, state, coin_req, coin_sel, remain, coin_cnt, busy, done, error);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; refund = 1'b0; balance = 10'd0; coin_rdy = 1'b1;
    #1;
    check_reset_values("reset_async");
    @(posedge clk); #1;
    check_reset_values("reset_held");
    #3 rst = 1'b1;
  endtask

  // Starts a payout with coin_rdy held 1 and checks coins, remainders,
  // done timing, final values and that they hold afterwards.
  task automatic run_payout(input string tag, input logic [9:0] bal,
                            input int exp_done_k, input logic [9:0] exp_final,
                            input logic exp_err);
    int n, pulses, done_k, first_req_k, pend_idx;
    logic prev_req, seen_done;
    coin_rdy = 1'b1;
    refund = 1'b1; balance = bal;
    @(posedge clk); #1;
    refund = 1'b0; balance = 10'($urandom_range(0, 1023));
    n = 0; pulses = 0; done_k = -1; first_req_k = -1; pend_idx = -1;
    prev_req = 1'b0; seen_done = 1'b0;
    total++;
    if (busy !== 1'b1 || remain !== bal) begin
      bad++;
      $display("FAIL %s_load: busy=%b rem=%0d, want busy=1 rem=%0d", tag, busy, remain, bal);
    end
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (pend_idx >= 0) begin
        total++;
        if (remain !== exp_rem_q[pend_idx]) begin
          bad++;
          $display("FAIL %s_remain%0d: got %0d want %0d", tag, pend_idx, remain, exp_rem_q[pend_idx]);
        end
        pend_idx = -1;
      end
      if (coin_req) begin
        if (first_req_k < 0) first_req_k = k;
        total++;
        if (prev_req !== 1'b0) begin
          bad++;
          $display("FAIL %s_gap: coin_req high two cycles in a row at k=%0d, want a low cycle", tag, k);
        end
        total++;
        if (n >= exp_coin_q.size()) begin
          bad++;
          $display("FAIL %s_extra_coin: got coin %b as coin %0d, want only %0d coins", tag, coin_sel, n, exp_coin_q.size());
        end else if (coin_sel !== exp_coin_q[n]) begin
          bad++;
          $display("FAIL %s_coin%0d: got %b want %b", tag, n, coin_sel, exp_coin_q[n]);
        end
        if (n < exp_rem_q.size()) pend_idx = n;
        n++;
      end
      prev_req = coin_req;
      if (done === 1'b1) begin
        pulses++;
        if (!seen_done) done_k = k;
        seen_done = 1'b1;
      end
      if (seen_done && busy === 1'b0) break;
    end
    total++;
    if (!seen_done || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: done_seen=%b busy=%b, want done then idle", tag, seen_done, busy);
    end
    total++;
    if (done_k != exp_done_k || pulses != 1) begin
      bad++;
      $display("FAIL %s_done: at k=%0d pulses=%0d, want k=%0d pulses=1", tag, done_k, pulses, exp_done_k);
    end
    if (exp_coin_q.size() > 0) begin
      total++;
      if (first_req_k != 1) begin
        bad++;
        $display("FAIL %s_first_req: at k=%0d want k=1", tag, first_req_k);
      end
    end
    total++;
    if (n != exp_coin_q.size() || coin_cnt !== 5'(exp_coin_q.size())) begin
      bad++;
      $display("FAIL %s_count: seen=%0d cnt=%0d want %0d", tag, n, coin_cnt, exp_coin_q.size());
    end
    total++;
    if (remain !== exp_final || error !== exp_err) begin
      bad++;
      $display("FAIL %s_final: rem=%0d err=%b want rem=%0d err=%b", tag, remain, error, exp_final, exp_err);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (remain !== exp_final || error !== exp_err || coin_cnt !== 5'(exp_coin_q.size()) || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_hold: rem=%0d err=%b cnt=%0d busy=%b want rem=%0d err=%b cnt=%0d busy=0",
               tag, remain, error, coin_cnt, busy, exp_final, exp_err, exp_coin_q.size());
    end
  endtask

  task automatic test_greedy_180();
    exp_coin_q = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_rem_q  = '{10'd80, 10'd30, 10'd10, 10'd0};
    run_payout("p180", 10'd180, 9, 10'd0, 1'b0);
  endtask

  task automatic test_residue_35();
    exp_coin_q = '{2'b10, 2'b11};
    exp_rem_q  = '{10'd15, 10'd5};
    run_payout("p35", 10'd35, 5, 10'd5, 1'b1);
  endtask

  task automatic test_zero();
    exp_coin_q = {};
    exp_rem_q  = {};
    run_payout("p0", 10'd0, 1, 10'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    exp_coin_q = '{2'b01, 2'b10, 2'b11};
    exp_rem_q  = '{10'd30, 10'd10, 10'd0};
    run_payout("p80", 10'd80, 7, 10'd0, 1'b0);
    exp_coin_q = '{2'b00, 2'b00, 2'b00};
    exp_rem_q  = '{10'd200, 10'd100, 10'd0};
    run_payout("p300", 10'd300, 7, 10'd0, 1'b0);
  endtask

  task automatic test_stall();
    logic ok;
    coin_rdy = 1'b0;
    refund = 1'b1; balance = 10'd100;
    @(posedge clk); #1;
    refund = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      total++;
      if (coin_req !== 1'b1 || coin_sel !== 2'b00 || remain !== 10'd100) begin
        bad++;
        $display("FAIL stall_hold%0d: req=%b sel=%b rem=%0d want req=1 sel=00 rem=100", k, coin_req, coin_sel, remain);
      end
    end
    coin_rdy = 1'b1;
    @(posedge clk); #1;
    total++;
    if (remain !== 10'd0 || coin_cnt !== 5'd1 || coin_req !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept: rem=%0d cnt=%0d req=%b want rem=0 cnt=1 req=0", remain, coin_cnt, coin_req);
    end
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || error !== 1'b0) begin
      bad++;
      $display("FAIL stall_finish: idle=%b err=%b want idle=1 err=0", ok, error);
    end
  endtask

  task automatic test_refund_ignored();
    int coins, wrong;
    logic seen_done;
    coin_rdy = 1'b1;
    refund = 1'b1; balance = 10'd200;
    @(posedge clk); #1;
    balance = 10'd50;
    coins = 0; wrong = 0; seen_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (coin_req) begin
        coins++;
        if (coin_sel !== 2'b00) wrong++;
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        refund = 1'b0;
        break;
      end
    end
    refund = 1'b0;
    @(posedge clk); #1;
    total++;
    if (!seen_done || coins != 2 || wrong != 0) begin
      bad++;
      $display("FAIL ignore_coins: done=%b coins=%0d non_d0=%0d want done=1 coins=2 non_d0=0", seen_done, coins, wrong);
    end
    total++;
    if (busy !== 1'b0 || remain !== 10'd0 || coin_cnt !== 5'd2 || error !== 1'b0) begin
      bad++;
      $display("FAIL ignore_final: busy=%b rem=%0d cnt=%0d err=%b want busy=0 rem=0 cnt=2 err=0", busy, remain, coin_cnt, error);
    end
  endtask

  task automatic test_reset_mid();
    coin_rdy = 1'b0;
    refund = 1'b1; balance = 10'd150;
    @(posedge clk); #1;
    refund = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (coin_req !== 1'b1 || remain !== 10'd150) begin
      bad++;
      $display("FAIL midrst_pre: req=%b rem=%0d want req=1 rem=150", coin_req, remain);
    end
    rst = 1'b0;
    #1;
    check_reset_values("midrst_async");
    @(posedge clk); #1;
    check_reset_values("midrst_held");
    #1 rst = 1'b1;
    exp_coin_q = '{2'b00, 2'b01};
    exp_rem_q  = '{10'd50, 10'd0};
    run_payout("p150", 10'd150, 5, 10'd0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_greedy_180();
    test_residue_35();
    test_zero();
    test_back_to_back();
    test_stall();
    test_refund_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- D0, 100: largest coin value (sen)
- D1, 50: second coin value
- D2, 20: third coin value
- D3, 10: smallest coin value; every other value SHALL be a multiple of D3
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1: single clock, rising edge
- rst, in, 1: asynchronous active-low reset
- refund, in, 1: one-cycle strobe from the vending-machine datapath; starts payout of balance
- balance, in, 10: unsigned amount to pay out (sen), valid when refund=1
- coin_rdy, in, 1: hopper accepts the currently requested coin
- coin_req, out, 1: coin request to hopper
- coin_sel, out, 2: requested coin (00=D0, 01=D1, 10=D2, 11=D3)
- remain, out, 10: amount still to pay out
- coin_cnt, out, 5: coins dispensed in the current/last payout, saturates at 31
- busy, out, 1: payout in progress
- done, out, 1: one-cycle end-of-payout pulse
- error, out, 1: remainder not payable (remain < D3 and nonzero at end)
- state, out, 3: FSM state for debug

Function
REQ-003 The block SHALL have exactly one clock domain, clk; rst SHALL be asynchronous and active-low.
REQ-004 FSM states SHALL be IDLE=000, SELECT=001, REQ=010, DONE=011; codes 100-111 SHALL return to IDLE on the next edge.
REQ-005 In IDLE, refund=1 at an edge: remain<=balance, coin_cnt<=0, error<=0, state<=SELECT.
REQ-006 refund SHALL be ignored in every state other than IDLE.
REQ-007 SELECT (one cycle) SHALL choose the greedy coin: remain>=D0 -> 00; else >=D1 -> 01; else >=D2 -> 10; else >=D3 -> 11; coin_sel registered, state<=REQ.
REQ-008 In SELECT with remain<D3: state<=DONE, error<=(remain!=0), and no coin is requested.
REQ-009 In REQ, coin_req SHALL be 1 and coin_sel SHALL stay stable until coin_rdy=1 is sampled.
REQ-010 REQ with coin_rdy=1 at an edge: remain<=remain-value(coin_sel), coin_cnt<=coin_cnt+1 (saturating at 31), state<=SELECT.
REQ-011 coin_req SHALL drop for at least one cycle (SELECT) between consecutive coins.
REQ-012 REQ with coin_rdy=0 SHALL hold indefinitely, with no timeout.
REQ-013 The first coin_req SHALL go high on the 2nd edge after the refund sample edge.
REQ-014 Each coin SHALL take 2 cycles when coin_rdy is held 1.
REQ-015 DONE SHALL assert done=1 for one cycle, then state<=IDLE.
REQ-016 remain, coin_cnt and error SHALL hold their final values until the next accepted refund.
REQ-017 busy SHALL be 1 in SELECT, REQ and DONE, and 0 in IDLE.
REQ-018 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from any input to any output.
REQ-019 Subtraction SHALL never underflow, because a coin is only selected when remain >= its value.
REQ-020 balance=0 SHALL go IDLE->SELECT->DONE with error=0 and coin_cnt=0.

Reset
REQ-021 With rst=0, outputs SHALL be immediately: state=IDLE, coin_req=0, coin_sel=00, remain=0, coin_cnt=0, busy=0, done=0, error=0.
REQ-022 Reset asserted mid-payout SHALL abort the payout; the unpaid amount is lost and no done pulse is generated.
REQ-023 The first refund SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-024 balance=180, coin_rdy=1 -> coins 00,01,10,11 in order; remain 80,30,10,0; coin_cnt=4; done at cycle 10 after refund edge; error=0.
REQ-025 balance=35 -> coins 10,11; remain=5; error=1; coin_cnt=2; single done pulse.
REQ-026 balance=0 -> no coin_req; done 2 cycles after the refund edge; error=0.
REQ-027 balance=100, coin_rdy held 0 for 7 cycles -> coin_req stays 1 and coin_sel=00 stable; remain=0 one edge after coin_rdy=1.
REQ-028 refund with balance=50 pulsed during busy of a 200 payout -> ignored; exactly 2×D0 paid.
REQ-029 rst=0 during REQ of a 150 payout -> all outputs at reset values immediately; a new refund after release pays its full balance.
